// File: rtl/coherence_bus_arbiter_pkg.sv
// Shared definitions for the coherence bus arbiter.
// This package holds the bus message encodings used by the L1 bus wrappers
// and the responder. It also holds the arbiter FSM state encoding.
package coherence_bus_arbiter_pkg;

    localparam int MSG_W = 4;

    // Bus message encodings.
    localparam logic [MSG_W-1:0] NO_REQ     = 4'd0;
    localparam logic [MSG_W-1:0] R_REQ      = 4'd1;
    localparam logic [MSG_W-1:0] RFO_BCST   = 4'd2;
    localparam logic [MSG_W-1:0] WB_REQ     = 4'd3;
    localparam logic [MSG_W-1:0] FLUSH      = 4'd4;
    localparam logic [MSG_W-1:0] FLUSH_S    = 4'd5;
    localparam logic [MSG_W-1:0] C_WB       = 4'd6;
    localparam logic [MSG_W-1:0] C_FLUSH    = 4'd7;
    localparam logic [MSG_W-1:0] MEM_RESP   = 4'd8;
    localparam logic [MSG_W-1:0] MEM_RESP_S = 4'd9;
    localparam logic [MSG_W-1:0] REQ_FLUSH  = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/coherence_bus_arbiter_rr.sv
// rr_priority_select: combinational round-robin pick.
// The search starts at the position just after last_grant and wraps around.
// Ports:
//   req          - one request bit per requester
//   last_grant   - index of the most recent master
//   grant_onehot - one-hot of the selected requester (zero if none)
//   grant_idx    - index of the selected requester
//   grant_valid  - at least one requester present
module rr_priority_select #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant_onehot,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    logic [IW-1:0] cand;

    // last_grant < N, so a single conditional subtract is enough to wrap.
    function automatic int wrap_idx(input int i);
        return (i >= N) ? i - N : i;
    endfunction

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        grant_valid  = 1'b0;
        cand         = '0;
        for (int off = 1; off <= N; off++) begin
            cand = IW'(wrap_idx(int'(last_grant) + off));
            if (!grant_valid && req[cand]) begin
                grant_valid        = 1'b1;
                grant_idx          = cand;
                grant_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// coherence_bus_arbiter: round-robin bus master selection and broadcast mux
// for the shared coherence bus between the L1 bus wrappers and the responder.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_IDLE    | no master; arbitrate among caches with a message != NO_REQ
//   ST_GRANT   | bus_master driven; hold timer loaded
//   ST_ACTIVE  | req_ready high; wait for master and responder to go idle
//   ST_RELEASE | one-cycle bus turnaround; round-robin pointer updated
//
// Ports:
//   clock, reset                  - clock; synchronous active-high reset
//   cache_msg/address/data/offset - packed per-cache bus outputs (slice i = cache i)
//   mem_msg/address/data_in       - responder outputs
//   bus_msg/address/data          - broadcast bus
//   curr_offset                   - offset of the current master
//   bus_master                    - one-hot grant
//   req_ready                     - master may issue its request
//   timeout_err                   - one-cycle pulse on forced release
module coherence_bus_arbiter
    import coherence_bus_arbiter_pkg::*;
#(
    parameter int NUM_CACHES      = 2,
    parameter int MSG_BITS        = 4,
    parameter int ADDRESS_BITS    = 32,
    parameter int BUS_WIDTH       = 128,
    parameter int MAX_OFFSET_BITS = 3,
    parameter int TIMEOUT_CYCLES  = 64,
    localparam int OW = $clog2(MAX_OFFSET_BITS) + 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_CACHES*MSG_BITS-1:0]     cache_msg_in,
    input  logic [NUM_CACHES*ADDRESS_BITS-1:0] cache_address_in,
    input  logic [NUM_CACHES*BUS_WIDTH-1:0]    cache_data_in,
    input  logic [NUM_CACHES*OW-1:0]           cache_offset_in,
    input  logic [MSG_BITS-1:0]                mem_msg_in,
    input  logic [ADDRESS_BITS-1:0]            mem_address_in,
    input  logic [BUS_WIDTH-1:0]               mem_data_in,
    output logic [MSG_BITS-1:0]                bus_msg,
    output logic [ADDRESS_BITS-1:0]            bus_address,
    output logic [BUS_WIDTH-1:0]               bus_data,
    output logic [OW-1:0]                      curr_offset,
    output logic [NUM_CACHES-1:0]              bus_master,
    output logic                               req_ready,
    output logic                               timeout_err
);

    localparam int IW = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [MSG_BITS-1:0] IDLE_MSG = MSG_BITS'(NO_REQ);

    arb_state_t          state;
    logic [NUM_CACHES-1:0] grant_q;
    logic [IW-1:0]       grant_idx_q;
    logic [IW-1:0]       last_grant_q;
    logic [CW-1:0]       hold_cnt;

    logic [NUM_CACHES-1:0] req_vec;
    logic [NUM_CACHES-1:0] rr_onehot;
    logic [IW-1:0]       rr_idx;
    logic                rr_valid;

    logic [MSG_BITS-1:0]     master_msg;
    logic [ADDRESS_BITS-1:0] master_address;
    logic [BUS_WIDTH-1:0]    master_data;
    logic [OW-1:0]           master_offset;
    logic                    mem_idle;
    logic                    in_tenure;

    for (genvar g = 0; g < NUM_CACHES; g++) begin : g_req
        assign req_vec[g] = cache_msg_in[g*MSG_BITS +: MSG_BITS] != IDLE_MSG;
    end

    rr_priority_select #(
        .N  (NUM_CACHES),
        .IW (IW)
    ) u_rr (
        .req          (req_vec),
        .last_grant   (last_grant_q),
        .grant_onehot (rr_onehot),
        .grant_idx    (rr_idx),
        .grant_valid  (rr_valid)
    );

    assign master_msg     = cache_msg_in[int'(grant_idx_q)*MSG_BITS +: MSG_BITS];
    assign master_address = cache_address_in[int'(grant_idx_q)*ADDRESS_BITS +: ADDRESS_BITS];
    assign master_data    = cache_data_in[int'(grant_idx_q)*BUS_WIDTH +: BUS_WIDTH];
    assign master_offset  = cache_offset_in[int'(grant_idx_q)*OW +: OW];
    assign mem_idle       = mem_msg_in == IDLE_MSG;
    assign in_tenure      = (state == ST_GRANT) || (state == ST_ACTIVE);
    assign bus_master     = grant_q;

    // The hold timer counts down from TIMEOUT_CYCLES-1. Reaching zero in ACTIVE
    // marks the last cycle a master may keep the bus.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            grant_q      <= '0;
            grant_idx_q  <= '0;
            last_grant_q <= IW'(NUM_CACHES - 1);
            hold_cnt     <= '0;
            req_ready    <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rr_valid) begin
                        grant_q     <= rr_onehot;
                        grant_idx_q <= rr_idx;
                        state       <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    hold_cnt  <= CW'(TIMEOUT_CYCLES - 1);
                    req_ready <= 1'b1;
                    state     <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if ((master_msg == IDLE_MSG) && mem_idle) begin
                        grant_q   <= '0;
                        req_ready <= 1'b0;
                        state     <= ST_RELEASE;
                    end else if (hold_cnt == '0) begin
                        timeout_err <= 1'b1;
                        grant_q     <= '0;
                        req_ready   <= 1'b0;
                        state       <= ST_RELEASE;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                ST_RELEASE: begin
                    last_grant_q <= grant_idx_q;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Responder traffic always wins the bus, whatever the arbitration state.
    always_comb begin
        bus_msg     = IDLE_MSG;
        bus_address = '0;
        bus_data    = '0;
        if (!mem_idle) begin
            bus_msg     = mem_msg_in;
            bus_address = mem_address_in;
            bus_data    = mem_data_in;
        end else if (in_tenure) begin
            bus_msg     = master_msg;
            bus_address = master_address;
            bus_data    = master_data;
        end
    end

    assign curr_offset = in_tenure ? master_offset : '0;

endmodule
